// File: rtl/bitserial_subtractor.sv
// LSB-first bit-serial subtractor: computes A-B mod 2^WIDTH one bit pair per accepted cycle.
// Define SUB_OVERFLOW_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module bitserial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             bit_valid,
  output logic             ready,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             overflow,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          borrow;
  logic          d;
  logic          br_next;
  logic          accept;
  logic          last;

  assign accept  = (state == RUN) && bit_valid;
  assign last    = (count == CW'(WIDTH - 1));
  assign d       = a_bit ^ b_bit ^ borrow;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  assign ready   = (state == RUN);
  assign done    = (state == DONE);

  // Each accepted difference bit enters at the MSB, so the first bit ends up in result[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      borrow     <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            count  <= '0;
            borrow <= 1'b0;
            result <= '0;
          end
        end
        RUN: begin
          if (bit_valid) begin
            result <= {d, result[WIDTH-1:1]};
            borrow <= br_next;
            count  <= count + 1'b1;
            if (last) begin
              state      <= DONE;
              borrow_out <= br_next;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_bit   <= 1'b0;
      diff_valid <= 1'b0;
    end else begin
      diff_valid <= accept;
      if (accept) begin
        diff_bit <= d;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (accept && last) begin
      overflow <= borrow ^ br_next;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
